// File: rtl/mac_enc.sv
// mac_enc: outbound frame encoder.
// Pops one descriptor from the header FIFO, then streams the matching body
// frame into the outbound PHY FIFOs selected by the descriptor bitmap.
// Short frames are zero-padded to MIN_LEN; long frames are cut at MAX_LEN
// and the rest of the body frame is flushed.
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   h_fifo_*             header FIFO (FWFT), [3:0] = port bitmap
//   b_fifo_*             body FIFO (FWFT), del marks the last byte
//   oN_fifo_*            outbound PHY FIFO N (din/del shared, wren per port)
//   tx_frame_cnt         frames emitted, drop_cnt zero-bitmap frames,
//   trunc_cnt            frames cut at MAX_LEN (all wrap)
module mac_enc #(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1514,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [7:0]       h_fifo_dout,
  input  logic             h_fifo_empty,
  output logic             h_fifo_rden,
  input  logic [7:0]       b_fifo_dout,
  input  logic             b_fifo_del,
  input  logic             b_fifo_empty,
  output logic             b_fifo_rden,
  output logic [7:0]       o0_fifo_din,
  output logic             o0_fifo_wren,
  output logic             o0_fifo_del,
  input  logic             o0_fifo_afull,
  output logic [7:0]       o1_fifo_din,
  output logic             o1_fifo_wren,
  output logic             o1_fifo_del,
  input  logic             o1_fifo_afull,
  output logic [7:0]       o2_fifo_din,
  output logic             o2_fifo_wren,
  output logic             o2_fifo_del,
  input  logic             o2_fifo_afull,
  output logic [7:0]       o3_fifo_din,
  output logic             o3_fifo_wren,
  output logic             o3_fifo_del,
  input  logic             o3_fifo_afull,
  output logic [CNT_W-1:0] tx_frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] trunc_cnt
);

  localparam int unsigned LEN_W = 11;
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, BODY, PAD, FLUSH, DROP} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]       mask, mask_nxt;
  logic [3:0]       wren_q, wren_nxt;
  logic [7:0]       din_q, din_nxt;
  logic             del_q, del_nxt;
  logic             tx_inc, drop_inc, trunc_inc;
  logic             h_rden_c, b_rden_c;
  logic [3:0]       afull;
  logic             ready;
  logic             unused_rsvd;

  assign unused_rsvd = ^h_fifo_dout[7:4];
  assign afull       = {o3_fifo_afull, o2_fifo_afull, o1_fifo_afull, o0_fifo_afull};
  // Only ports in the latched mask can hold the frame back.
  assign ready       = (mask & afull) == 4'd0;
  assign cnt_inc     = cnt + LEN_W'(1);

  // Pops are combinational so the FWFT word is consumed in the cycle it is used;
  // held low while reset is asserted.
  assign h_fifo_rden = h_rden_c & arst_n;
  assign b_fifo_rden = b_rden_c & arst_n;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state, pop strobes and next output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mask_nxt  = mask;
    wren_nxt  = 4'd0;
    din_nxt   = din_q;
    del_nxt   = 1'b0;
    h_rden_c  = 1'b0;
    b_rden_c  = 1'b0;
    tx_inc    = 1'b0;
    drop_inc  = 1'b0;
    trunc_inc = 1'b0;
    case (state)
      IDLE: begin
        if (!h_fifo_empty) begin
          h_rden_c  = 1'b1;
          mask_nxt  = h_fifo_dout[3:0];
          cnt_nxt   = '0;
          state_nxt = (h_fifo_dout[3:0] != 4'd0) ? BODY : DROP;
        end
      end
      BODY: begin
        if (!b_fifo_empty && ready) begin
          b_rden_c = 1'b1;
          wren_nxt = mask;
          din_nxt  = b_fifo_dout;
          cnt_nxt  = cnt_inc;
          // A delimiter on the MAX_LEN byte is a normal end, so it is tested first.
          if (b_fifo_del) begin
            if (cnt_inc >= MIN_L) begin
              del_nxt   = 1'b1;
              tx_inc    = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = PAD;
            end
          end else if (cnt_inc == MAX_L) begin
            del_nxt   = 1'b1;
            tx_inc    = 1'b1;
            trunc_inc = 1'b1;
            state_nxt = FLUSH;
          end
        end
      end
      PAD: begin
        if (ready) begin
          wren_nxt = mask;
          din_nxt  = 8'h00;
          cnt_nxt  = cnt_inc;
          if (cnt_inc == MIN_L) begin
            del_nxt   = 1'b1;
            tx_inc    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      FLUSH, DROP: begin
        // Discard body bytes up to the delimiter; output backpressure is irrelevant.
        if (!b_fifo_empty) begin
          b_rden_c = 1'b1;
          if (b_fifo_del) begin
            drop_inc  = (state == DROP);
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, output and statistics registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt          <= '0;
      mask         <= 4'd0;
      wren_q       <= 4'd0;
      din_q        <= 8'h00;
      del_q        <= 1'b0;
      tx_frame_cnt <= '0;
      drop_cnt     <= '0;
      trunc_cnt    <= '0;
    end else begin
      cnt    <= cnt_nxt;
      mask   <= mask_nxt;
      wren_q <= wren_nxt;
      din_q  <= din_nxt;
      del_q  <= del_nxt;
      if (tx_inc)    tx_frame_cnt <= tx_frame_cnt + CNT_W'(1);
      if (drop_inc)  drop_cnt     <= drop_cnt + CNT_W'(1);
      if (trunc_inc) trunc_cnt    <= trunc_cnt + CNT_W'(1);
    end
  end

  assign o0_fifo_din  = din_q;
  assign o1_fifo_din  = din_q;
  assign o2_fifo_din  = din_q;
  assign o3_fifo_din  = din_q;
  assign o0_fifo_del  = del_q;
  assign o1_fifo_del  = del_q;
  assign o2_fifo_del  = del_q;
  assign o3_fifo_del  = del_q;
  assign o0_fifo_wren = wren_q[0];
  assign o1_fifo_wren = wren_q[1];
  assign o2_fifo_wren = wren_q[2];
  assign o3_fifo_wren = wren_q[3];

endmodule

// File: tb/tb_mac_enc.sv
// tb_mac_enc: self-checking bench for mac_enc.
// FWFT header/body FIFOs are modelled with queues; every frame pushed is also
// turned into the expected per-port byte stream from the pad/truncate/drop
// rules, and the captured PHY writes are compared against it.
module tb_mac_enc;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  h_dout;
  logic        h_empty;
  logic        h_rden;
  logic [7:0]  b_dout;
  logic        b_del;
  logic        b_empty;
  logic        b_rden;
  logic [7:0]  o_din [4];
  logic [3:0]  o_wren;
  logic [3:0]  o_del;
  logic [3:0]  af;
  logic [15:0] tx_frame_cnt, drop_cnt, trunc_cnt;

  always #5 clk = ~clk;

  mac_enc dut (
    .clk(clk), .arst_n(arst_n),
    .h_fifo_dout(h_dout), .h_fifo_empty(h_empty), .h_fifo_rden(h_rden),
    .b_fifo_dout(b_dout), .b_fifo_del(b_del), .b_fifo_empty(b_empty), .b_fifo_rden(b_rden),
    .o0_fifo_din(o_din[0]), .o0_fifo_wren(o_wren[0]), .o0_fifo_del(o_del[0]), .o0_fifo_afull(af[0]),
    .o1_fifo_din(o_din[1]), .o1_fifo_wren(o_wren[1]), .o1_fifo_del(o_del[1]), .o1_fifo_afull(af[1]),
    .o2_fifo_din(o_din[2]), .o2_fifo_wren(o_wren[2]), .o2_fifo_del(o_del[2]), .o2_fifo_afull(af[2]),
    .o3_fifo_din(o_din[3]), .o3_fifo_wren(o_wren[3]), .o3_fifo_del(o_del[3]), .o3_fifo_afull(af[3]),
    .tx_frame_cnt(tx_frame_cnt), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
  );

  // Stimulus FIFOs, expected and captured streams ({del, byte})
  logic [7:0] hq [$];
  logic [8:0] bq [$];
  logic [8:0] exp_q [4][$];
  logic [8:0] got_q [4][$];

  int checks = 0;
  int errors = 0;
  int m_tx = 0, m_drop = 0, m_trunc = 0;
  int af_viol = 0, empty_pop_viol = 0, both_viol = 0;
  int wr0 = 0, h_seen = 0;
  bit h_pop = 0, b_pop = 0;
  bit stall_en = 0, af_rand = 0;
  logic [3:0] af_force = 4'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // FIFO/PHY environment: capture writes, apply pops, drive inputs, sample pops.
  always @(negedge clk) begin
    logic [8:0] bv;
    if (arst_n) begin
      for (int p = 0; p < 4; p++) begin
        if (o_wren[p]) begin
          got_q[p].push_back({o_del[p], o_din[p]});
          if (af[p]) af_viol++;
          if (p == 0) wr0++;
        end
      end
    end
    if (h_pop && hq.size() > 0) void'(hq.pop_front());
    if (b_pop && bq.size() > 0) void'(bq.pop_front());
    af      = af_rand ? (4'($urandom) & 4'($urandom)) : af_force;
    h_empty = (hq.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
    h_dout  = (hq.size() > 0) ? hq[0] : 8'($urandom);
    b_empty = (bq.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
    bv      = (bq.size() > 0) ? bq[0] : 9'($urandom);
    b_dout  = bv[7:0];
    b_del   = bv[8];
    #4;
    h_pop = h_rden;
    b_pop = b_rden;
    if ((h_rden && h_empty) || (b_rden && b_empty)) empty_pop_viol++;
    if (h_rden && b_rden) both_viol++;
    if (h_rden) h_seen++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Queue one frame and extend the expected per-port streams.
  task automatic push_frame(input logic [3:0] mask, input int len, input bit rnd, input logic [7:0] base);
    logic [7:0] bytes [$];
    logic [7:0] b;
    int outl;
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : 8'(int'(base) + i);
      bytes.push_back(b);
      bq.push_back({(i == len - 1), b});
    end
    hq.push_back({4'($urandom), mask});
    if (mask == 4'd0) begin
      m_drop++;
    end else begin
      outl = (len > MAX_LEN) ? MAX_LEN : ((len < MIN_LEN) ? MIN_LEN : len);
      if (len > MAX_LEN) m_trunc++;
      m_tx++;
      for (int p = 0; p < 4; p++)
        if (mask[p])
          for (int i = 0; i < outl; i++)
            exp_q[p].push_back({(i == outl - 1), (i < len) ? bytes[i] : 8'h00});
    end
  endtask

  function automatic bit all_out();
    bit ok = (hq.size() == 0) && (bq.size() == 0);
    for (int p = 0; p < 4; p++)
      if (got_q[p].size() < exp_q[p].size()) ok = 0;
    return ok;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!all_out() && n < budget) begin
      step(1);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
    step(10);
  endtask

  // Compare captured vs expected streams per port and all statistics.
  task automatic compare(input string tag);
    int e0;
    int n;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s_p%0d_len", tag, p), 64'(got_q[p].size()), 64'(exp_q[p].size()));
      n = (got_q[p].size() < exp_q[p].size()) ? got_q[p].size() : exp_q[p].size();
      for (int i = 0; i < n; i++) begin
        e0 = errors;
        chk($sformatf("%s_p%0d_b%0d", tag, p, i), 64'(got_q[p][i]), 64'(exp_q[p][i]));
        if (errors != e0) break;
      end
      got_q[p].delete();
      exp_q[p].delete();
    end
    chk({tag, "_tx_cnt"},    64'(tx_frame_cnt), 64'(16'(m_tx)));
    chk({tag, "_drop_cnt"},  64'(drop_cnt),     64'(16'(m_drop)));
    chk({tag, "_trunc_cnt"}, 64'(trunc_cnt),    64'(16'(m_trunc)));
    chk({tag, "_afull_wr"},  64'(af_viol),        64'd0);
    chk({tag, "_empty_pop"}, 64'(empty_pop_viol), 64'd0);
    chk({tag, "_both_pop"},  64'(both_viol),      64'd0);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({o_wren, o_del, o_din[0], o_din[1], o_din[2], o_din[3], h_rden, b_rden,
                tx_frame_cnt, drop_cnt, trunc_cnt});
  endfunction

  initial begin
    int w;
    int n;
    arst_n  = 1'b0;
    h_empty = 1'b1;
    b_empty = 1'b1;
    h_dout  = 8'h00;
    b_dout  = 8'h00;
    b_del   = 1'b0;
    af      = 4'd0;
    #1;
    chk("reset_state", out_vec(), 64'd0);
    step(2);
    arst_n = 1'b1;
    step(2);

    // Single port, 12-byte body padded to 60
    push_frame(4'h1, 12, 0, 8'h10);
    wait_done("pad", 2000);
    compare("pad");

    // Broadcast, 64 bytes, no padding
    push_frame(4'hF, 64, 0, 8'h80);
    wait_done("bcast", 2000);
    compare("bcast");

    // Backpressure on o2 (in mask) stalls; on o1 (outside mask) does not
    push_frame(4'h5, 64, 0, 8'h40);
    n = 0;
    while (wr0 < 10 && n < 500) begin step(1); n++; end
    chk("bp_start", 64'(n < 500), 64'd1);
    af_force = 4'b0100;
    w = wr0;
    step(20);
    chk("bp_o2_stall", 64'((wr0 - w) <= 1), 64'd1);
    af_force = 4'b0010;
    w = wr0;
    step(20);
    chk("bp_o1_ignored", 64'((wr0 - w) >= 15), 64'd1);
    af_force = 4'd0;
    wait_done("bp", 2000);
    compare("bp");

    // Truncation, exact MAX_LEN end, one-over, then a clean short frame
    push_frame(4'h2, 1600, 1, 8'h00);
    push_frame(4'h4, 20, 0, 8'hA0);
    push_frame(4'h1, MAX_LEN, 1, 8'h00);
    push_frame(4'h8, MAX_LEN + 1, 1, 8'h00);
    wait_done("trunc", 20000);
    compare("trunc");

    // Zero bitmap dropped, following frame intact
    push_frame(4'h0, 100, 1, 8'h00);
    push_frame(4'h8, 60, 0, 8'hC0);
    wait_done("zero", 2000);
    compare("zero");

    // Randomized traffic with FIFO stalls and random afull on all ports
    stall_en = 1;
    af_rand  = 1;
    for (int k = 0; k < 30; k++) begin
      logic [3:0] m;
      int len;
      m   = ($urandom_range(0, 6) == 0) ? 4'd0 : 4'($urandom);
      len = ($urandom_range(0, 9) < 2) ? $urandom_range(MIN_LEN - 2, MIN_LEN + 2)
                                       : $urandom_range(1, 140);
      push_frame(m, len, 1, 8'h00);
    end
    wait_done("rand", 40000);
    af_rand  = 0;
    stall_en = 0;
    step(2);
    compare("rand");

    // Reset in the middle of a frame
    push_frame(4'h1, 100, 0, 8'h00);
    n = 0;
    while (got_q[0].size() < 30 && n < 500) begin step(1); n++; end
    chk("mrst_start", 64'(n < 500), 64'd1);
    arst_n = 1'b0;
    #1;
    chk("mrst_outputs", out_vec(), 64'd0);
    hq.delete();
    bq.delete();
    for (int p = 0; p < 4; p++) begin
      got_q[p].delete();
      exp_q[p].delete();
    end
    m_tx = 0; m_drop = 0; m_trunc = 0;
    step(3);
    arst_n = 1'b1;
    w = h_seen;
    step(8);
    chk("mrst_idle_wait", 64'(h_seen - w), 64'd0);
    push_frame(4'h3, 70, 1, 8'h00);
    wait_done("mrst", 2000);
    compare("mrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
